// File: rtl/neopixel_rx_pkg.sv
// Shared WS2812 timing constants and receiver types.
// The transmitter uses the same constants, so both ends agree on one timing source.
package neopixel_rx_pkg;

   localparam int unsigned CNT_W       = 11;
   localparam int unsigned WORD_BITS   = 24;
   localparam int unsigned RST_CYC_DEF = 1000;

   // 800 kHz timing, in 20 MHz clock cycles
   localparam logic [CNT_W-1:0] T0H_800K    = 11'd8;
   localparam logic [CNT_W-1:0] T1H_800K    = 11'd16;
   localparam logic [CNT_W-1:0] MIN_HI_800K = 11'd4;
   localparam logic [CNT_W-1:0] THRESH_800K = 11'd12;
   localparam logic [CNT_W-1:0] MAX_HI_800K = 11'd24;

   // 400 kHz timing, in 20 MHz clock cycles
   localparam logic [CNT_W-1:0] T0H_400K    = 11'd10;
   localparam logic [CNT_W-1:0] T1H_400K    = 11'd24;
   localparam logic [CNT_W-1:0] MIN_HI_400K = 11'd6;
   localparam logic [CNT_W-1:0] THRESH_400K = 11'd17;
   localparam logic [CNT_W-1:0] MAX_HI_400K = 11'd40;

   typedef enum logic [1:0] {StSync, StIdle, StHigh} rx_state_t;

   typedef struct packed {
      logic [CNT_W-1:0] min_hi;
      logic [CNT_W-1:0] thresh;
      logic [CNT_W-1:0] max_hi;
   } hi_lim_t;

   function automatic hi_lim_t hi_limits(input logic mode);
      hi_lim_t l;
      if (mode) begin
         l.min_hi = MIN_HI_400K;
         l.thresh = THRESH_400K;
         l.max_hi = MAX_HI_400K;
      end else begin
         l.min_hi = MIN_HI_800K;
         l.thresh = THRESH_800K;
         l.max_hi = MAX_HI_800K;
      end
      return l;
   endfunction

endpackage

// File: rtl/neopixel_rx_sync.sv
// Two-flop synchroniser for the asynchronous neopixel line, with one-cycle
// rise/fall pulses derived from the synchronised level.
module neopixel_rx_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 stream decoder: recovers 24-bit words, flags latch gaps and framing errors.
module neopixel_rx
   import neopixel_rx_pkg::*;
#(
   parameter int unsigned RST_CYC = RST_CYC_DEF,
   parameter int unsigned PIX_W   = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_mode,
   input  logic             i_neo_rx,
   output logic [23:0]      o_rgb,
   output logic             o_rgb_valid,
   output logic             o_latch,
   output logic             o_frame_err,
   output logic [PIX_W-1:0] o_pix_cnt
);

   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_CYC);

   logic w_level;
   logic w_rise;
   logic w_fall;

   neopixel_rx_sync u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_neo_rx),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   rx_state_t        r_state;
   rx_state_t        w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mode;
   logic [23:0]      r_shift;
   logic [4:0]       r_bit_cnt;
   logic [PIX_W-1:0] r_pix_cnt;
   logic             r_word_done;
   logic [23:0]      r_rgb;
   logic             r_rgb_valid;

   hi_lim_t          w_lim;
   logic             w_too_short;
   logic             w_too_long;
   logic             w_gap;
   logic             w_bit;
   logic [23:0]      w_shift_next;
   logic             w_bit_en;
   logic             w_err;
   logic             w_latch;
   logic             w_gap_clr;

   // Limits follow the mode captured at the most recent rising edge
   assign w_lim        = hi_limits(r_mode);
   assign w_too_short  = r_cnt < w_lim.min_hi;
   assign w_too_long   = w_level && (r_cnt == w_lim.max_hi);
   assign w_gap        = !w_level && (r_cnt == RST_VAL);
   assign w_bit        = r_cnt >= w_lim.thresh;
   assign w_shift_next = {r_shift[22:0], w_bit};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StSync;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StSync: if (w_gap) w_state_next = StIdle;
         StIdle: if (w_rise) w_state_next = StHigh;
         StHigh: begin
            if (w_too_long || (w_fall && w_too_short)) begin
               w_state_next = StSync;
            end else if (w_fall) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StSync;
      endcase
   end

   always_comb begin
      w_bit_en  = 1'b0;
      w_err     = 1'b0;
      w_latch   = 1'b0;
      w_gap_clr = 1'b0;
      unique case (r_state)
         StIdle: begin
            // cnt passes RST_VAL once per low stretch, so this fires once per gap
            if (w_gap) begin
               w_gap_clr = 1'b1;
               if (r_bit_cnt != 5'd0) begin
                  w_err = 1'b1;
               end else if (r_pix_cnt != '0) begin
                  w_latch = 1'b1;
               end
            end
         end
         StHigh: begin
            if (w_too_long || (w_fall && w_too_short)) begin
               w_err = 1'b1;
            end else if (w_fall) begin
               w_bit_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_pix_cnt   <= '0;
         r_word_done <= 1'b0;
         r_rgb       <= '0;
         r_rgb_valid <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         r_rgb_valid <= r_word_done;
         if (w_rise) begin
            r_mode <= i_mode;
         end
         if (w_rise || w_fall || (r_state == StSync && w_level)) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_err || w_gap_clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_pix_cnt <= '0;
         end else if (w_bit_en) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == 5'(WORD_BITS - 1)) begin
               r_bit_cnt   <= '0;
               r_rgb       <= w_shift_next;
               r_word_done <= 1'b1;
               if (r_pix_cnt != '1) begin
                  r_pix_cnt <= r_pix_cnt + PIX_W'(1);
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end
      end
   end

   assign o_rgb       = r_rgb;
   assign o_rgb_valid = r_rgb_valid;
   assign o_latch     = w_latch;
   assign o_frame_err = w_err;
   assign o_pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx: a bench-side transmitter drives the line and
// pushes expected events; a monitor pops and compares on every DUT strobe.
module tb_neopixel_rx;

   localparam int unsigned PIX_W = 10;

   logic             clk  = 1'b0;
   logic             rst  = 1'b0;
   logic             mode = 1'b0;
   logic             line = 1'b0;
   logic [23:0]      rgb;
   logic             rgb_valid;
   logic             latch;
   logic             ferr;
   logic [PIX_W-1:0] pix;

   neopixel_rx #(
      .RST_CYC (1000),
      .PIX_W   (PIX_W)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mode      (mode),
      .i_neo_rx    (line),
      .o_rgb       (rgb),
      .o_rgb_valid (rgb_valid),
      .o_latch     (latch),
      .o_frame_err (ferr),
      .o_pix_cnt   (pix)
   );

   always #25 clk = ~clk;

   typedef enum int {EvRgb, EvLatch, EvErr} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int unsigned data;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  total = 0;
   int  bad   = 0;
   // Reference model of the current frame: bits of an unfinished word, complete words
   int  m_bits  = 0;
   int  m_words = 0;

   function automatic void check(input string name, input longint unsigned act,
                                 input longint unsigned req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   task automatic hold(input logic lvl, input int n);
      line = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      int th;
      int per;
      per = mode ? 50 : 25;
      th  = mode ? (b ? 24 : 10) : (b ? 16 : 8);
      hold(1'b1, th);
      hold(1'b0, per - th);
   endtask

   task automatic send_word(input logic [23:0] w);
      exp_q.push_back('{kind: EvRgb, data: 32'(w)});
      m_words++;
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_partial(input int n);
      m_bits += n;
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1)));
   endtask

   task automatic send_gap();
      if (m_bits != 0) begin
         exp_q.push_back('{kind: EvErr, data: 0});
      end else if (m_words != 0) begin
         exp_q.push_back('{kind: EvLatch, data: (m_words > 1023) ? 1023 : m_words});
      end
      m_bits  = 0;
      m_words = 0;
      hold(1'b0, 1100);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_rgb"}, rgb, 0);
      check({tag, "_rgb_valid"}, rgb_valid, 0);
      check({tag, "_latch"}, latch, 0);
      check({tag, "_frame_err"}, ferr, 0);
      check({tag, "_pix_cnt"}, pix, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && (rgb_valid || latch || ferr)) begin
         check("strobe_exclusive", 32'(rgb_valid) + 32'(latch) + 32'(ferr), 1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe actual valid=%0b latch=%0b err=%0b required=none",
                     rgb_valid, latch, ferr);
         end else begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
               EvRgb: begin
                  check("rgb_valid", rgb_valid, 1);
                  check("rgb_word", rgb, mon_e.data);
               end
               EvLatch: begin
                  check("latch", latch, 1);
                  check("latch_pix_cnt", pix, mon_e.data);
               end
               default: check("frame_err", ferr, 1);
            endcase
         end
      end
   end

   initial begin
      int nw;
      // 1: reset state, single 800k word then latch
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;
      mode = 1'b0;
      hold(1'b0, 1100);
      send_word(24'hFF0055);
      send_gap();

      // 2: three 400k words
      mode = 1'b1;
      send_word(24'h123456);
      send_word(24'hABCDEF);
      send_word(24'h000000);
      send_gap();

      // 3: partial word at gap
      mode = 1'b0;
      send_partial(10);
      send_gap();
      check("partial_pix_cnt_after", pix, 0);

      // 4: glitch mid-word, then resync and decode
      send_partial(5);
      exp_q.push_back('{kind: EvErr, data: 0});
      m_bits  = 0;
      m_words = 0;
      hold(1'b1, 2);
      hold(1'b0, 1100);
      send_word(24'h5A0FC3);
      send_gap();

      // 5: stuck high beyond MAX_HI
      exp_q.push_back('{kind: EvErr, data: 0});
      hold(1'b1, 230);
      hold(1'b0, 1100);
      check("stuck_pix_cnt_after", pix, 0);

      // 6: random loopback frames, mode picked per word
      nw = 0;
      while (nw < 36) begin
         int fl;
         fl = $urandom_range(6, 1);
         for (int k = 0; k < fl; k++) begin
            mode = 1'($urandom_range(1));
            send_word(24'($urandom));
         end
         nw += fl;
         send_gap();
      end

      // reset mid-word: a buffered word and partial bits vanish without a strobe
      mode = 1'b0;
      send_word(24'($urandom));
      hold(1'b0, 20);
      check("pre_reset_pix_cnt", pix, 1);
      for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1)));
      rst = 1'b1;
      m_bits  = 0;
      m_words = 0;
      repeat (3) @(negedge clk);
      check_cleared("midword_reset");
      rst = 1'b0;
      hold(1'b0, 1100);
      mode = 1'b1;
      send_word(24'($urandom));
      send_gap();

      hold(1'b0, 50);
      check("events_outstanding", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
